// File: rtl/datapath_control_unit_if.sv
// Control-strobe bundle between the sequencer and the single-bus datapath.
// Latency: none, this is wiring only.
// Backpressure: MemReady is the only flow-control signal; strobes are level-valued per cycle.
//
// Signals
//   IR[31:0]   instruction register contents (opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15])
//   MemReady   memory read data valid this cycle
//   Stop       request to halt at the next instruction boundary
//   PCout..LOin  single-bit datapath strobes
//   Rin/Rout   one-hot general-register load / drive enables
//   ALUop      operation presented to the ALU
//   Run        high while executing; Illegal pulses on an undecodable opcode
//   State      current sequencer state, for debug
// Modports: master = sequencer side, slave = datapath (or bench) side.
interface datapath_control_unit_if;
    logic [31:0] IR;
    logic        MemReady;
    logic        Stop;

    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        MDRout;
    logic        Read;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        ZLOout;
    logic        ZHIout;
    logic        HIin;
    logic        LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  ALUop;
    logic        Run;
    logic        Illegal;
    logic [3:0]  State;

    modport master (
        input  IR, MemReady, Stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, LOin,
               Rin, Rout, ALUop, Run, Illegal, State
    );

    modport slave (
        output IR, MemReady, Stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
               Yin, Zin, ZLOout, ZHIout, HIin, LOin,
               Rin, Rout, ALUop, Run, Illegal, State
    );
endinterface

// File: rtl/datapath_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the single-bus datapath strobes.
// Latency: one state per Clock; fetch is T0..T2 plus memory wait, ALU ops finish in T5.
// Backpressure: holds in T1 (Read/MDRin asserted) until MemReady; PCin fires once on the ready cycle.
//
// Ports
//   Clock     rising-edge clock for all state
//   Reset     synchronous, active-high; forces T0 and blanks every output while high
//   bus       datapath_control_unit_if.master: IR/MemReady/Stop in, strobes/Rin/Rout/ALUop/Run/Illegal/State out
// Build option: define MULDIV_EN to decode OP_MUL/OP_DIV (T3..T6 HI/LO sequence);
// without it those opcodes are illegal and T6 is never entered.
module datapath_control_unit #(
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011,
    parameter logic [4:0] OP_MUL  = 5'b10000,
    parameter logic [4:0] OP_DIV  = 5'b01111
) (
    input  logic                          Clock,
    input  logic                          Reset,
    datapath_control_unit_if.master       bus
);

`ifdef MULDIV_EN
    localparam bit MULDIV_ON = 1'b1;
`else
    localparam bit MULDIV_ON = 1'b0;
`endif

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        HALT = 4'd15
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlo_out;
        logic zhi_out;
        logic hi_in;
        logic lo_in;
    } strobe_t;

    state_t      state;
    state_t      state_nxt;
    state_t      boundary_nxt;
    strobe_t     strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu_op;
    logic        illegal;
    logic        run;

    // IR field split
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        is_alu;
    logic        is_muldiv;
    logic        unused_ir_bits;

    assign opcode = bus.IR[31:27];
    assign ra     = bus.IR[26:23];
    assign rb     = bus.IR[22:19];
    assign rc     = bus.IR[18:15];
    assign unused_ir_bits = ^bus.IR[14:0];

    // add, sub, shr, shra, shl, ror, rol, and, or occupy a contiguous opcode range
    assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    assign is_muldiv = MULDIV_ON && ((opcode == OP_MUL) || (opcode == OP_DIV));

    // Stop is only looked at when an instruction retires
    assign boundary_nxt = bus.Stop ? HALT : T0;

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        onehot = 16'd1 << idx;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        strb      = '0;
        rin       = '0;
        rout      = '0;
        alu_op    = '0;
        illegal   = 1'b0;
        run       = 1'b0;
        state_nxt = HALT;

        case (state)
            T0: begin
                run         = 1'b1;
                strb.pc_out = 1'b1;
                strb.mar_in = 1'b1;
                strb.inc_pc = 1'b1;
                strb.z_in   = 1'b1;
                state_nxt   = T1;
            end
            T1: begin
                run          = 1'b1;
                strb.zlo_out = 1'b1;
                strb.read    = 1'b1;
                strb.mdr_in  = 1'b1;
                // PC loads only on the ready cycle so a long wait still advances PC once
                if (bus.MemReady) begin
                    strb.pc_in = 1'b1;
                    state_nxt  = T2;
                end else begin
                    state_nxt  = T1;
                end
            end
            T2: begin
                run          = 1'b1;
                strb.mdr_out = 1'b1;
                strb.ir_in   = 1'b1;
                state_nxt    = T3;
            end
            T3: begin
                run = 1'b1;
                if (is_alu) begin
                    rout      = onehot(rb);
                    strb.y_in = 1'b1;
                    state_nxt = T4;
                end else if (is_muldiv) begin
                    rout      = onehot(ra);
                    strb.y_in = 1'b1;
                    state_nxt = T4;
                end else if (opcode == OP_HALT) begin
                    state_nxt = HALT;
                end else begin
                    // NOP and undecodable opcodes both retire here
                    illegal   = (opcode != OP_NOP);
                    state_nxt = boundary_nxt;
                end
            end
            T4: begin
                run       = 1'b1;
                strb.z_in = 1'b1;
                alu_op    = opcode;
                rout      = is_muldiv ? onehot(rb) : onehot(rc);
                state_nxt = T5;
            end
            T5: begin
                run          = 1'b1;
                strb.zlo_out = 1'b1;
                if (is_muldiv) begin
                    strb.lo_in = 1'b1;
                    state_nxt  = T6;
                end else begin
                    rin        = onehot(ra);
                    state_nxt  = boundary_nxt;
                end
            end
            T6: begin
                run = 1'b1;
                if (is_muldiv) begin
                    strb.zhi_out = 1'b1;
                    strb.hi_in   = 1'b1;
                    state_nxt    = boundary_nxt;
                end else begin
                    state_nxt    = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase

        // Reset blanks everything immediately, including the cycle before its first edge
        if (Reset) begin
            strb    = '0;
            rin     = '0;
            rout    = '0;
            alu_op  = '0;
            illegal = 1'b0;
            run     = 1'b0;
        end
    end

    assign bus.PCout   = strb.pc_out;
    assign bus.PCin    = strb.pc_in;
    assign bus.IncPC   = strb.inc_pc;
    assign bus.MARin   = strb.mar_in;
    assign bus.MDRin   = strb.mdr_in;
    assign bus.MDRout  = strb.mdr_out;
    assign bus.Read    = strb.read;
    assign bus.IRin    = strb.ir_in;
    assign bus.Yin     = strb.y_in;
    assign bus.Zin     = strb.z_in;
    assign bus.ZLOout  = strb.zlo_out;
    assign bus.ZHIout  = strb.zhi_out;
    assign bus.HIin    = strb.hi_in;
    assign bus.LOin    = strb.lo_in;
    assign bus.Rin     = rin;
    assign bus.Rout    = rout;
    assign bus.ALUop   = alu_op;
    assign bus.Run     = run;
    assign bus.Illegal = illegal;
    assign bus.State   = Reset ? 4'd0 : state;

endmodule
